pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the IF/ID pipeline register: carries instruction + PC between two pipeline stages.
- Uses a valid/ready handshake on both sides instead of a bare enable.
- A 2-entry skid buffer (main + skid) keeps `in_ready` a pure register output, so there is no combinational path from `out_ready` to `in_ready`.
- Adds a synchronous flush that injects a NOP bubble; reusable for IF/ID, ID/EX and later stages.

Parameters:
- `INSTR_W`, 32, width of the instruction/payload field
- `PC_W`, 32, width of the PC field
- `NOP_INSTR`, 32'h00000013, value driven on `out_instr` while `out_valid`=0 (RISC-V addi x0,x0,0); width `INSTR_W`
- `CNT_W`, 16, width of the statistics counters (used only with `PIPE_STATS_EN`)

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous squash of all held entries
- `in_valid`  in  1  upstream presents `in_instr`/`in_pc`
- `in_ready`  out  1  stage can accept; transfer when `in_valid` & `in_ready`
- `in_instr`  in  `INSTR_W`  instruction from upstream stage
- `in_pc`  in  `PC_W`  PC from upstream stage
- `out_valid`  out  1  `out_instr`/`out_pc` hold a live entry
- `out_ready`  in  1  downstream consumes; pop when `out_valid` & `out_ready`
- `out_instr`  out  `INSTR_W`  instruction to downstream stage
- `out_pc`  out  `PC_W`  PC to downstream stage
- `stall_cnt`  out  `CNT_W`  only with `PIPE_STATS_EN`
- `flush_cnt`  out  `CNT_W`  only with `PIPE_STATS_EN`

Behaviour:
- State: EMPTY (no entry), ONE (main valid), FULL (main + skid valid). Outputs are driven directly from the main registers.
- Reset (sync, active-high, highest priority):
  - state EMPTY.
  - `out_valid`=0, `out_instr`=`NOP_INSTR`, `out_pc`=0.
  - Skid contents cleared.
  - `in_ready`=0 while `reset` is high; 1 from the first cycle after deassertion.
- `in_ready` = (state != FULL) && !`reset`. It depends on no input other than `reset`.
- Notation: accept = `in_valid` & `in_ready`; pop = `out_valid` & `out_ready`.
- Transitions when not flushed:
  - EMPTY, accept -> main<=in, ONE.
  - EMPTY, no accept -> hold.
  - ONE, accept & pop -> main<=in, stay ONE.
  - ONE, accept & !pop -> skid<=in, FULL.
  - ONE, !accept & pop -> main instr<=`NOP_INSTR`, pc holds, EMPTY.
  - ONE, neither -> hold.
  - FULL, pop -> main<=skid, ONE.
  - FULL, no pop -> hold all (`in_ready`=0).
- Latency: 1 cycle input-to-output when EMPTY. Throughput: 1 entry/cycle when `out_ready` is held high.
- Ordering: strict FIFO. An entry in skid always leaves after main.
- `flush` (priority below `reset`, above everything else):
  - Next state EMPTY; `out_valid`=0; `out_instr`=`NOP_INSTR`; `out_pc` holds; skid dropped.
  - An input accepted in the same cycle (accept=1) is discarded; upstream treats it as transferred.
  - A pop in the same cycle still counts as consumed by downstream.
- Stability: while `out_valid`=1 and `out_ready`=0, `out_instr`/`out_pc` must not change.
- Payload is not required to be stable while `in_valid`=0.
- X on `in_instr`/`in_pc` with `in_valid`=0 must never reach the outputs.

Optional Feature:
- Macro: `PIPE_STATS_EN`.
- Defined: ports `stall_cnt` and `flush_cnt` exist.
  - `stall_cnt` increments each cycle with `out_valid`=1 & `out_ready`=0.
  - `flush_cnt` increments each cycle with `flush`=1 (not during `reset`).
  - Both saturate at 2^`CNT_W`-1 and are cleared to 0 by `reset`. `flush` does not clear them.
- Undefined: both ports and all counter logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset -> `out_valid`=0, `out_instr`=32'h00000013, `out_pc`=0, `in_ready`=0 during reset and 1 the next cycle.
- Streaming, `out_ready`=1: push instr 0xA0..0xA3 with pc 0x00,0x04,0x08,0x0C on consecutive cycles -> same sequence on the outputs, 1-cycle latency, `in_ready` stays 1.
- Backpressure: with `out_ready`=0, push 0xB0 (pc 0x10), 0xB1 (pc 0x14), then offer 0xB2:
  - `in_ready` drops to 0 after the second accept; 0xB2 is not taken.
  - Raise `out_ready` -> 0xB0, 0xB1, 0xB2 emerge in order; outputs stable while stalled.
- Flush from FULL with `in_valid`=1 (0xC0) in the same cycle -> next cycle `out_valid`=0, `out_instr`=0x00000013, `in_ready`=1; 0xC0 never appears.
- Reset mid-FULL with `out_ready`=0 -> all reset values next cycle; prior entries never appear on the outputs.
- `PIPE_STATS_EN`, `CNT_W`=4: hold `out_valid`=1, `out_ready`=0 for 20 cycles -> `stall_cnt`=15 (saturated); 3 flush pulses -> `flush_cnt`=3.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer and NOP-injecting flush.
// Optional statistics counters (stall_cnt, flush_cnt) are built when PIPE_STATS_EN is defined.
module pipe_stage_skid #(
`ifdef PIPE_STATS_EN
   parameter int CNT_W = 16,
`endif
   parameter int INSTR_W = 32,
   parameter int PC_W = 32,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(32'h00000013)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [INSTR_W-1:0] in_instr,
   input  logic [PC_W-1:0]    in_pc,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [INSTR_W-1:0] out_instr,
   output logic [PC_W-1:0]    out_pc
`ifdef PIPE_STATS_EN
   ,
   output logic [CNT_W-1:0]   stall_cnt,
   output logic [CNT_W-1:0]   flush_cnt
`endif
);

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   state_t               state_q, state_d;
   logic [INSTR_W-1:0]   main_instr_q, main_instr_d;
   logic [PC_W-1:0]      main_pc_q, main_pc_d;
   logic [INSTR_W-1:0]   skid_instr_q, skid_instr_d;
   logic [PC_W-1:0]      skid_pc_q, skid_pc_d;
   logic                 accept;
   logic                 pop;

   // in_ready decodes only the state register, so out_ready never reaches it
   assign in_ready  = (state_q != FULL) && !reset;
   assign out_valid = (state_q != EMPTY);
   assign out_instr = main_instr_q;
   assign out_pc    = main_pc_q;
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_comb begin
      state_d      = state_q;
      main_instr_d = main_instr_q;
      main_pc_d    = main_pc_q;
      skid_instr_d = skid_instr_q;
      skid_pc_d    = skid_pc_q;
      if (flush) begin
         // the squashed entry's PC stays visible; only the instruction turns into a bubble
         state_d      = EMPTY;
         main_instr_d = NOP_INSTR;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_instr_d = in_instr;
                  main_pc_d    = in_pc;
                  state_d      = ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_instr_d = in_instr;
                  main_pc_d    = in_pc;
               end else if (accept) begin
                  skid_instr_d = in_instr;
                  skid_pc_d    = in_pc;
                  state_d      = FULL;
               end else if (pop) begin
                  main_instr_d = NOP_INSTR;
                  state_d      = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  main_instr_d = skid_instr_q;
                  main_pc_d    = skid_pc_q;
                  state_d      = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= EMPTY;
         main_instr_q <= NOP_INSTR;
         main_pc_q    <= '0;
         skid_instr_q <= '0;
         skid_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         main_instr_q <= main_instr_d;
         main_pc_q    <= main_pc_d;
         skid_instr_q <= skid_instr_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

`ifdef PIPE_STATS_EN
   // saturating counters; flush deliberately leaves them untouched
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios then random traffic, checked against a queue model.
// Define PIPE_STATS_EN to also check the statistics counters (built with CNT_W=4).
module tb_pipe_stage_skid;

   localparam logic [31:0] NOP = 32'h00000013;
   localparam int CNT_W = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
`ifdef PIPE_STATS_EN
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;
`endif

   entry_t q[$];
   logic [31:0] shown_pc;
   int stall_m;
   int flush_m;
   int total;
   int bad;

`ifdef PIPE_STATS_EN
   pipe_stage_skid #(.CNT_W(CNT_W), .INSTR_W(32), .PC_W(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );
`else
   pipe_stage_skid #(.INSTR_W(32), .PC_W(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic compare(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic checkOutput(input logic rst);
      compare("out_valid", 64'(out_valid), 64'(q.size() != 0));
      compare("out_instr", 64'(out_instr), 64'((q.size() != 0) ? q[0].instr : NOP));
      compare("out_pc", 64'(out_pc), 64'(shown_pc));
      compare("in_ready", 64'(in_ready), 64'(!rst && (q.size() < 2)));
`ifdef PIPE_STATS_EN
      compare("stall_cnt", 64'(stall_cnt), 64'(stall_m));
      compare("flush_cnt", 64'(flush_cnt), 64'(flush_m));
`endif
   endtask

   // One clock of stimulus: drive, check current outputs, advance the model, step the clock
   task automatic applyStimulus(input logic rst, input logic fl, input logic iv,
                                input logic [31:0] instr, input logic [31:0] pc, input logic ordy);
      logic m_valid, m_ready, acc, pp;
      entry_t e;
      reset     = rst;
      flush     = fl;
      in_valid  = iv;
      in_instr  = iv ? instr : 'x;
      in_pc     = iv ? pc : 'x;
      out_ready = ordy;
      #1;
      checkOutput(rst);
      m_valid = (q.size() != 0);
      m_ready = !rst && (q.size() < 2);
      acc     = iv && m_ready;
      pp      = m_valid && ordy;
      e.instr = instr;
      e.pc    = pc;
      if (rst) begin
         q.delete();
         shown_pc = '0;
         stall_m  = 0;
         flush_m  = 0;
      end else begin
         if (m_valid && !ordy && stall_m < CNT_MAX) stall_m++;
         if (fl && flush_m < CNT_MAX) flush_m++;
         if (fl) begin
            q.delete();
         end else begin
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (q.size() != 0) shown_pc = q[0].pc;
         end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad = 0;
      stall_m = 0;
      flush_m = 0;
      shown_pc = '0;
      reset = 1'b1;
      flush = 1'b0;
      in_valid = 1'b0;
      in_instr = 'x;
      in_pc = 'x;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      $display("[TB] reset");
      applyStimulus(1, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);

      $display("[TB] streaming");
      for (int i = 0; i < 4; i++)
         applyStimulus(0, 0, 1, 32'hA0 + i, 32'(4 * i), 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);

      $display("[TB] backpressure");
      applyStimulus(0, 0, 1, 32'hB0, 32'h10, 0);
      applyStimulus(0, 0, 1, 32'hB1, 32'h14, 0);
      applyStimulus(0, 0, 1, 32'hB2, 32'h18, 0);
      applyStimulus(0, 0, 1, 32'hB2, 32'h18, 0);
      applyStimulus(0, 0, 1, 32'hB2, 32'h18, 1);
      applyStimulus(0, 0, 1, 32'hB2, 32'h18, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);

      $display("[TB] flush from full");
      applyStimulus(0, 0, 1, 32'hD0, 32'h20, 0);
      applyStimulus(0, 0, 1, 32'hD1, 32'h24, 0);
      applyStimulus(0, 1, 1, 32'hC0, 32'h28, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);

      $display("[TB] reset while full");
      applyStimulus(0, 0, 1, 32'hE0, 32'h30, 0);
      applyStimulus(0, 0, 1, 32'hE1, 32'h34, 0);
      applyStimulus(1, 0, 1, 32'hE2, 32'h38, 0);
      applyStimulus(0, 0, 0, 0, 0, 1);
      applyStimulus(0, 0, 0, 0, 0, 1);

      $display("[TB] long stall and flush pulses");
      applyStimulus(0, 0, 1, 32'hF0, 32'h40, 0);
      for (int i = 0; i < 20; i++)
         applyStimulus(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1, 0, 0, 0, 0);
         applyStimulus(0, 0, 0, 0, 0, 1);
      end
      applyStimulus(0, 0, 0, 0, 0, 1);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(99) < 2), ($urandom_range(99) < 5),
                       ($urandom_range(99) < 60), $urandom, $urandom,
                       ($urandom_range(99) < 60));
      end
      applyStimulus(0, 0, 0, 0, 0, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
